// File: rtl/colour_filter_ctrl.sv
// Frame-synchronous colour filter between the VGA timing core and the DAC pins.
// Define CF_FRAME_STATS_EN to build the per-frame hit counter; otherwise oHIT_CNT/oHIT_VALID are tied low.
//
// state     | meaning
// SYNC_WAIT | after reset: bypass only, no counting, waiting for first iVS fall
// ACTIVE    | filtering with oMODE, counting hits, reporting each frame
module colour_filter_ctrl #(
  parameter int unsigned THRESH = 128,
  parameter int unsigned CNT_W  = 19
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [2:0]       iMODE_REQ,
  input  logic             iMODE_STB,
  input  logic             iVS,
  input  logic             iBLANK_N,
  input  logic [7:0]       iR,
  input  logic [7:0]       iG,
  input  logic [7:0]       iB,
  output logic [7:0]       oR,
  output logic [7:0]       oG,
  output logic [7:0]       oB,
  output logic             oBLANK_N,
  output logic [2:0]       oMODE,
  output logic             oBUSY,
  output logic [CNT_W-1:0] oHIT_CNT,
  output logic             oHIT_VALID
);

  typedef enum logic {SYNC_WAIT = 1'b0, ACTIVE = 1'b1} state_e;

  localparam logic [7:0] THR = 8'(THRESH);

  state_e      state_q, state_d;
  logic        vs_q;
  logic        frame_edge;
  logic        filter_en;

  logic [2:0]  mode_q, mode_d;
  logic [2:0]  pend_q, pend_d;
  logic        busy_q, busy_d;

  logic [2:0]  mode_eff;
  logic        hit_r, hit_g, hit_b, hit_sel;
  logic [9:0]  y_sum;

  logic [7:0]  r_s1_q, g_s1_q, b_s1_q, y_s1_q;
  logic [7:0]  r_s1_d, g_s1_d, b_s1_d, y_s1_d;
  logic        hit_s1_q, hit_s1_d;
  logic        blank_s1_q, blank_s1_d;
  logic [2:0]  mode_s1_q, mode_s1_d;

  logic [7:0]  r_out_q, g_out_q, b_out_q;
  logic [7:0]  r_out_d, g_out_d, b_out_d;
  logic        blank_out_q, blank_out_d;

  assign frame_edge = vs_q & ~iVS;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= iVS;
    end
  end

  // FSM: state register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= SYNC_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC_WAIT: if (frame_edge) state_d = ACTIVE;
      ACTIVE:    state_d = ACTIVE;
      default:   state_d = SYNC_WAIT;
    endcase
  end

`ifdef CF_FRAME_STATS_EN
  logic report_edge;
`endif

  // FSM: outputs
  always_comb begin
    filter_en = (state_q == ACTIVE);
`ifdef CF_FRAME_STATS_EN
    report_edge = (state_q == ACTIVE) && frame_edge;
`endif
  end

  // The edge applies whatever was pending before this cycle; a same-cycle strobe waits for the next edge.
  always_comb begin
    mode_d = mode_q;
    busy_d = busy_q;
    pend_d = pend_q;
    if (frame_edge) begin
      if (busy_q) mode_d = pend_q;
      busy_d = 1'b0;
    end
    if (iMODE_STB) begin
      pend_d = iMODE_REQ;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mode_q <= 3'd0;
      pend_q <= 3'd0;
      busy_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

  assign mode_eff = filter_en ? mode_q : 3'd0;

  assign hit_r = (iR >= THR) && (iR > iG) && (iR > iB);
  assign hit_g = (iG >= THR) && (iG > iR) && (iG > iB);
  assign hit_b = (iB >= THR) && (iB > iR) && (iB > iG);

  assign y_sum = {2'b00, iR} + {1'b0, iG, 1'b0} + {2'b00, iB};

  always_comb begin
    hit_sel = 1'b0;
    case (mode_eff)
      3'd1, 3'd5: hit_sel = hit_r;
      3'd2:       hit_sel = hit_g;
      3'd3:       hit_sel = hit_b;
      default:    hit_sel = 1'b0;
    endcase
  end

  always_comb begin
    r_s1_d     = iR;
    g_s1_d     = iG;
    b_s1_d     = iB;
    y_s1_d     = y_sum[9:2];
    hit_s1_d   = hit_sel & iBLANK_N;
    blank_s1_d = iBLANK_N;
    mode_s1_d  = mode_eff;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_s1_q     <= 8'd0;
      g_s1_q     <= 8'd0;
      b_s1_q     <= 8'd0;
      y_s1_q     <= 8'd0;
      hit_s1_q   <= 1'b0;
      blank_s1_q <= 1'b0;
      mode_s1_q  <= 3'd0;
    end else begin
      r_s1_q     <= r_s1_d;
      g_s1_q     <= g_s1_d;
      b_s1_q     <= b_s1_d;
      y_s1_q     <= y_s1_d;
      hit_s1_q   <= hit_s1_d;
      blank_s1_q <= blank_s1_d;
      mode_s1_q  <= mode_s1_d;
    end
  end

  always_comb begin
    r_out_d     = 8'd0;
    g_out_d     = 8'd0;
    b_out_d     = 8'd0;
    blank_out_d = blank_s1_q;
    if (blank_s1_q) begin
      case (mode_s1_q)
        3'd1, 3'd2, 3'd3: begin
          r_out_d = hit_s1_q ? r_s1_q : y_s1_q;
          g_out_d = hit_s1_q ? g_s1_q : y_s1_q;
          b_out_d = hit_s1_q ? b_s1_q : y_s1_q;
        end
        3'd4: begin
          r_out_d = y_s1_q;
          g_out_d = y_s1_q;
          b_out_d = y_s1_q;
        end
        3'd5: begin
          r_out_d = {8{hit_s1_q}};
          g_out_d = {8{hit_s1_q}};
          b_out_d = {8{hit_s1_q}};
        end
        default: begin
          r_out_d = r_s1_q;
          g_out_d = g_s1_q;
          b_out_d = b_s1_q;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_out_q     <= 8'd0;
      g_out_q     <= 8'd0;
      b_out_q     <= 8'd0;
      blank_out_q <= 1'b0;
    end else begin
      r_out_q     <= r_out_d;
      g_out_q     <= g_out_d;
      b_out_q     <= b_out_d;
      blank_out_q <= blank_out_d;
    end
  end

  assign oR       = r_out_q;
  assign oG       = g_out_q;
  assign oB       = b_out_q;
  assign oBLANK_N = blank_out_q;
  assign oMODE    = mode_q;
  assign oBUSY    = busy_q;

`ifdef CF_FRAME_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             hit_valid_q, hit_valid_d;

  // The stage-1 flag present on the edge cycle seeds the new frame's count.
  always_comb begin
    acc_d       = acc_q;
    hit_cnt_d   = hit_cnt_q;
    hit_valid_d = 1'b0;
    if (report_edge) begin
      hit_cnt_d   = acc_q;
      hit_valid_d = 1'b1;
    end
    if (frame_edge) begin
      acc_d = {{(CNT_W-1){1'b0}}, hit_s1_q};
    end else if (hit_s1_q && (acc_q != CNT_MAX)) begin
      acc_d = acc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      acc_q       <= '0;
      hit_cnt_q   <= '0;
      hit_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      hit_cnt_q   <= hit_cnt_d;
      hit_valid_q <= hit_valid_d;
    end
  end

  assign oHIT_CNT   = hit_cnt_q;
  assign oHIT_VALID = hit_valid_q;
`else
  assign oHIT_CNT   = '0;
  assign oHIT_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_colour_filter_ctrl.sv
// Randomised self-checking bench for colour_filter_ctrl against a frame-level behavioural model.
module tb_colour_filter_ctrl;
  localparam int CNT_W = 19;
`ifdef CF_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             iCLK = 1'b0;
  logic             iRST_N = 1'b0;
  logic [2:0]       iMODE_REQ = 3'd0;
  logic             iMODE_STB = 1'b0;
  logic             iVS = 1'b1;
  logic             iBLANK_N = 1'b0;
  logic [7:0]       iR = 8'd0, iG = 8'd0, iB = 8'd0;
  logic [7:0]       oR, oG, oB;
  logic             oBLANK_N;
  logic [2:0]       oMODE;
  logic             oBUSY;
  logic [CNT_W-1:0] oHIT_CNT;
  logic             oHIT_VALID;

  colour_filter_ctrl #(.THRESH(128), .CNT_W(CNT_W)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iMODE_REQ(iMODE_REQ), .iMODE_STB(iMODE_STB),
    .iVS(iVS), .iBLANK_N(iBLANK_N), .iR(iR), .iG(iG), .iB(iB),
    .oR(oR), .oG(oG), .oB(oB), .oBLANK_N(oBLANK_N), .oMODE(oMODE), .oBUSY(oBUSY),
    .oHIT_CNT(oHIT_CNT), .oHIT_VALID(oHIT_VALID)
  );

  always #20 iCLK = ~iCLK;

  int n_chk = 0;
  int n_pass = 0;

  // model state
  logic [2:0]       m_mode, m_pend;
  logic             m_busy, m_active, m_vs_prev, m_hit_prev, m_blank_s1;
  int               m_acc;
  logic [23:0]      m_out_s1;
  logic [23:0]      exp_rgb;
  logic             exp_blank, exp_valid;
  logic [CNT_W-1:0] exp_cnt;

  function automatic bit px_hit(logic [2:0] mode, logic [7:0] r, logic [7:0] g, logic [7:0] b);
    int c, o1, o2;
    case (mode)
      3'd1, 3'd5: begin c = r; o1 = g; o2 = b; end
      3'd2:       begin c = g; o1 = r; o2 = b; end
      3'd3:       begin c = b; o1 = r; o2 = g; end
      default:    return 1'b0;
    endcase
    return (c >= 128) && (c > o1) && (c > o2);
  endfunction

  function automatic logic [23:0] px_out(logic [2:0] mode, logic [23:0] p, logic blank);
    int y;
    logic [7:0] yy;
    bit h;
    if (!blank) return 24'h0;
    y  = (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
    yy = y[7:0];
    h  = px_hit(mode, p[23:16], p[15:8], p[7:0]);
    case (mode)
      3'd1, 3'd2, 3'd3: return h ? p : {yy, yy, yy};
      3'd4:             return {yy, yy, yy};
      3'd5:             return h ? 24'hFFFFFF : 24'h000000;
      default:          return p;
    endcase
  endfunction

  function automatic logic [23:0] rand_px();
    logic [23:0] p;
    int k;
    p = 24'($urandom);
    k = $urandom_range(0, 3);
    if (k != 0) p[(3 - k) * 8 +: 8] = 8'($urandom_range(128, 255));
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 3'd0; m_pend = 3'd0; m_busy = 1'b0; m_active = 1'b0;
    m_vs_prev = 1'b1; m_hit_prev = 1'b0; m_blank_s1 = 1'b0; m_acc = 0;
    m_out_s1 = 24'h0; exp_rgb = 24'h0; exp_blank = 1'b0; exp_valid = 1'b0;
    exp_cnt = '0;
  endtask

  // Drive one pixel-clock cycle and advance the model to what the outputs should show after the edge.
  task automatic step(logic stb, logic [2:0] req, logic vs, logic blank, logic [23:0] px);
    logic edge_s, h;
    logic [2:0] eff;
    iMODE_STB = stb; iMODE_REQ = req; iVS = vs; iBLANK_N = blank;
    {iR, iG, iB} = px;
    edge_s = m_vs_prev && !vs;
    eff = m_active ? m_mode : 3'd0;
    h = blank && px_hit(eff, px[23:16], px[15:8], px[7:0]);
    exp_rgb = m_out_s1;
    exp_blank = m_blank_s1;
    m_out_s1 = px_out(eff, px, blank);
    m_blank_s1 = blank;
    exp_valid = 1'b0;
    if (edge_s) begin
      if (m_active && STATS) begin
        exp_cnt = CNT_W'(m_acc);
        exp_valid = 1'b1;
      end
      m_acc = m_hit_prev ? 1 : 0;
      m_active = 1'b1;
      if (m_busy) m_mode = m_pend;
      m_busy = 1'b0;
    end else if (m_hit_prev && m_acc < (2 ** CNT_W) - 1) begin
      m_acc++;
    end
    m_hit_prev = h;
    if (stb) begin
      m_pend = req;
      m_busy = 1'b1;
    end
    m_vs_prev = vs;
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    iRST_N = 1'b0;
    iVS = 1'b1; iBLANK_N = 1'b1; {iR, iG, iB} = 24'hABCDEF;
    repeat (3) @(posedge iCLK);
    #1;
    n_chk++;
    if ({oR, oG, oB, oBLANK_N, oMODE, oBUSY, oHIT_CNT, oHIT_VALID} !== '0)
      $display("FAIL reset_outputs got rgb=%h bl=%b mode=%0d busy=%b cnt=%0d v=%b exp all 0",
               {oR, oG, oB}, oBLANK_N, oMODE, oBUSY, oHIT_CNT, oHIT_VALID);
    else n_pass++;
    iRST_N = 1'b1;
  endtask

  task automatic test_bypass_and_first_edge();
    step(1'b0, 3'd0, 1'b1, 1'b1, 24'h123456);
    step(1'b0, 3'd0, 1'b1, 1'b1, 24'h000000);
    n_chk++;
    if ({oR, oG, oB, oBLANK_N} !== {24'h123456, 1'b1})
      $display("FAIL bypass_latency got %h/%b exp 123456/1", {oR, oG, oB}, oBLANK_N);
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      step(i == 20, 3'd1, 1'b1, 1'($urandom_range(0, 1)), rand_px());
      n_chk++;
      if ({oR, oG, oB, oBLANK_N} !== {exp_rgb, exp_blank})
        $display("FAIL sync_wait_pix got %h/%b exp %h/%b", {oR, oG, oB}, oBLANK_N, exp_rgb, exp_blank);
      else n_pass++;
    end
    n_chk++;
    if ({oMODE, oBUSY} !== {3'd0, 1'b1})
      $display("FAIL pending_before_edge got mode=%0d busy=%b exp mode=0 busy=1", oMODE, oBUSY);
    else n_pass++;
    step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
    n_chk++;
    if ({oMODE, oBUSY, oHIT_VALID} !== {3'd1, 1'b0, 1'b0})
      $display("FAIL first_edge got mode=%0d busy=%b v=%b exp mode=1 busy=0 v=0", oMODE, oBUSY, oHIT_VALID);
    else n_pass++;
    repeat (3) step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic test_mode1();
    step(1'b0, 3'd0, 1'b1, 1'b1, 24'hC81010);
    step(1'b0, 3'd0, 1'b1, 1'b1, 24'h408040);
    n_chk++;
    if ({oR, oG, oB} !== 24'hC81010)
      $display("FAIL mode1_hit got %h exp c81010", {oR, oG, oB});
    else n_pass++;
    step(1'b0, 3'd0, 1'b1, 1'b1, 24'h000000);
    n_chk++;
    if ({oR, oG, oB} !== 24'h606060)
      $display("FAIL mode1_gray got %h exp 606060", {oR, oG, oB});
    else n_pass++;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 3'd0, 1'b1, 1'($urandom_range(0, 3) != 0), rand_px());
      n_chk++;
      if ({oR, oG, oB, oBLANK_N} !== {exp_rgb, exp_blank})
        $display("FAIL mode1_pix got %h/%b exp %h/%b", {oR, oG, oB}, oBLANK_N, exp_rgb, exp_blank);
      else n_pass++;
    end
  endtask

  task automatic test_last_wins();
    for (int i = 0; i < 20; i++) begin
      step(i == 5 || i == 10, (i == 5) ? 3'd2 : 3'd3, 1'b1, 1'b1, rand_px());
      n_chk++;
      if ({oR, oG, oB, oMODE, oBUSY} !== {exp_rgb, m_mode, m_busy})
        $display("FAIL lastwins_pix got %h m=%0d b=%b exp %h m=%0d b=%b",
                 {oR, oG, oB}, oMODE, oBUSY, exp_rgb, m_mode, m_busy);
      else n_pass++;
    end
    step(1'b1, 3'd5, 1'b0, 1'b0, 24'h0);
    n_chk++;
    if ({oMODE, oBUSY} !== {3'd3, 1'b1})
      $display("FAIL edge_strobe got mode=%0d busy=%b exp mode=3 busy=1", oMODE, oBUSY);
    else n_pass++;
    repeat (3) step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 3'd0, 1'b1, 1'b1, rand_px());
      n_chk++;
      if ({oR, oG, oB, oBLANK_N} !== {exp_rgb, exp_blank})
        $display("FAIL mode3_pix got %h/%b exp %h/%b", {oR, oG, oB}, oBLANK_N, exp_rgb, exp_blank);
      else n_pass++;
    end
    repeat (3) step(1'b0, 3'd0, 1'b1, 1'b0, 24'h0);
    step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
    n_chk++;
    if ({oMODE, oBUSY, oHIT_VALID, oHIT_CNT} !== {3'd5, 1'b0, exp_valid, exp_cnt})
      $display("FAIL second_apply got mode=%0d busy=%b v=%b cnt=%0d exp mode=5 busy=0 v=%b cnt=%0d",
               oMODE, oBUSY, oHIT_VALID, oHIT_CNT, exp_valid, exp_cnt);
    else n_pass++;
    repeat (3) step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic test_mask_count();
    int n_red, n_yel;
    logic [23:0] p;
    n_red = 1000;
    n_yel = 500;
    while (n_red + n_yel > 0) begin
      if (n_yel == 0 || (n_red > 0 && $urandom_range(0, 2) != 0)) begin
        p = 24'hFF0000; n_red--;
      end else begin
        p = 24'h808000; n_yel--;
      end
      step(1'b0, 3'd0, 1'b1, 1'b1, p);
      n_chk++;
      if ({oR, oG, oB, oBLANK_N} !== {exp_rgb, exp_blank})
        $display("FAIL mask_pix got %h/%b exp %h/%b", {oR, oG, oB}, oBLANK_N, exp_rgb, exp_blank);
      else n_pass++;
    end
    repeat (3) step(1'b0, 3'd0, 1'b1, 1'b0, 24'h0);
    step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
    n_chk++;
    if ({oHIT_VALID, oHIT_CNT} !== {STATS, (STATS ? CNT_W'(1000) : CNT_W'(0))})
      $display("FAIL mask_count got v=%b cnt=%0d exp v=%b cnt=%0d", oHIT_VALID, oHIT_CNT, STATS, STATS ? 1000 : 0);
    else n_pass++;
    step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
    n_chk++;
    if (oHIT_VALID !== 1'b0)
      $display("FAIL valid_one_cycle got %b exp 0", oHIT_VALID);
    else n_pass++;
    repeat (2) step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic test_blank();
    for (int i = 0; i < 70; i++) begin
      step(1'b0, 3'd0, 1'b1, i >= 50, 24'hFF0000);
      n_chk++;
      if ({oR, oG, oB, oBLANK_N} !== {exp_rgb, exp_blank})
        $display("FAIL blank_pix got %h/%b exp %h/%b", {oR, oG, oB}, oBLANK_N, exp_rgb, exp_blank);
      else n_pass++;
    end
    repeat (3) step(1'b0, 3'd0, 1'b1, 1'b0, 24'h0);
    step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
    n_chk++;
    if ({oHIT_VALID, oHIT_CNT} !== {STATS, (STATS ? CNT_W'(20) : CNT_W'(0))})
      $display("FAIL blank_count got v=%b cnt=%0d exp v=%b cnt=%0d", oHIT_VALID, oHIT_CNT, STATS, STATS ? 20 : 0);
    else n_pass++;
    repeat (3) step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic test_random_frames();
    logic stb;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 250; i++) begin
        stb = ($urandom_range(0, 40) == 0);
        step(stb, 3'($urandom), 1'b1, 1'($urandom_range(0, 4) != 0), rand_px());
        n_chk++;
        if ({oR, oG, oB, oBLANK_N} !== {exp_rgb, exp_blank})
          $display("FAIL rand_pix got %h/%b exp %h/%b", {oR, oG, oB}, oBLANK_N, exp_rgb, exp_blank);
        else n_pass++;
      end
      for (int i = 0; i < 4; i++) begin
        stb = (i == 0) && ($urandom_range(0, 1) == 1);
        step(stb, 3'($urandom), 1'b0, 1'b0, 24'h0);
        n_chk++;
        if ({oMODE, oBUSY, oHIT_VALID, oHIT_CNT} !== {m_mode, m_busy, exp_valid, exp_cnt})
          $display("FAIL rand_status got m=%0d b=%b v=%b c=%0d exp m=%0d b=%b v=%b c=%0d",
                   oMODE, oBUSY, oHIT_VALID, oHIT_CNT, m_mode, m_busy, exp_valid, exp_cnt);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midframe();
    step(1'b1, 3'd1, 1'b1, 1'b0, 24'h0);
    step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
    step(1'b0, 3'd0, 1'b1, 1'b0, 24'h0);
    repeat (30) step(1'b0, 3'd0, 1'b1, 1'b1, 24'hF01010);
    #10;
    iRST_N = 1'b0;
    #1;
    n_chk++;
    if ({oR, oG, oB, oBLANK_N, oMODE, oBUSY, oHIT_CNT, oHIT_VALID} !== '0)
      $display("FAIL midframe_reset got rgb=%h bl=%b mode=%0d busy=%b cnt=%0d v=%b exp all 0",
               {oR, oG, oB}, oBLANK_N, oMODE, oBUSY, oHIT_CNT, oHIT_VALID);
    else n_pass++;
    @(posedge iCLK);
    #1;
    iRST_N = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 3'd0, 1'b1, 1'b1, 24'hF01010);
      n_chk++;
      if ({oR, oG, oB, oBLANK_N} !== {exp_rgb, exp_blank})
        $display("FAIL post_reset_pix got %h/%b exp %h/%b", {oR, oG, oB}, oBLANK_N, exp_rgb, exp_blank);
      else n_pass++;
    end
    step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
    n_chk++;
    if ({oHIT_VALID, oMODE, oHIT_CNT} !== {1'b0, 3'd0, CNT_W'(0)})
      $display("FAIL post_reset_edge got v=%b mode=%0d cnt=%0d exp v=0 mode=0 cnt=0", oHIT_VALID, oMODE, oHIT_CNT);
    else n_pass++;
    repeat (3) step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
    repeat (20) step(1'b0, 3'd0, 1'b1, 1'b1, 24'hF01010);
    step(1'b0, 3'd0, 1'b0, 1'b0, 24'h0);
    n_chk++;
    if ({oHIT_VALID, oHIT_CNT} !== {STATS, CNT_W'(0)})
      $display("FAIL post_reset_report got v=%b cnt=%0d exp v=%b cnt=0", oHIT_VALID, oHIT_CNT, STATS);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bypass_and_first_edge();
    test_mode1();
    test_last_wins();
    test_mask_count();
    test_blank();
    test_random_frames();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
